// File: rtl/booth_pkg.sv
// Shared Booth digit type, window encoder and elaboration-time sizing helpers
// for the pipelined Booth multiplier.
package booth_pkg;

  typedef enum logic [2:0] {
    BD_ZERO = 3'b000,
    BD_P1   = 3'b001,
    BD_P2   = 3'b010,
    BD_M1   = 3'b101,
    BD_M2   = 3'b110
  } booth_digit_t;

  // Window is {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_digit_t booth_encode(input logic [2:0] win);
    booth_digit_t d;
    case (win)
      3'b001, 3'b010: d = BD_P1;
      3'b011:         d = BD_P2;
      3'b100:         d = BD_M2;
      3'b101, 3'b110: d = BD_M1;
      default:        d = BD_ZERO;
    endcase
    return d;
  endfunction

  function automatic int pp_num(input int width);
    return width / 2 + 1;
  endfunction

  function automatic int csa_rows_next(input int n);
    return (n / 3) * 2 + (n % 3);
  endfunction

  function automatic int csa_rows_at(input int n0, input int lvl);
    int n;
    n = n0;
    for (int i = 0; i < lvl; i++) n = csa_rows_next(n);
    return n;
  endfunction

  function automatic int csa_levels(input int n0);
    int n;
    int l;
    n = n0;
    l = 0;
    while (n > 2) begin
      n = csa_rows_next(n);
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product generator: one 2*WIDTH row per digit plus a
// row collecting the +1 corrections of negated digits.
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter  int WIDTH  = 16,
  localparam int PP_NUM = pp_num(WIDTH),
  localparam int NROWS  = PP_NUM + 1
) (
  input  logic [WIDTH+1:0]   a_ext_i,
  input  logic [WIDTH+1:0]   b_ext_i,
  output logic [2*WIDTH-1:0] rows_o [NROWS]
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]    a_w;
  logic [WIDTH+2:0] b_win;
  logic [PW-1:0]    corr;

  assign a_w   = {{(WIDTH-2){a_ext_i[WIDTH+1]}}, a_ext_i};
  assign b_win = {b_ext_i, 1'b0};

  for (genvar i = 0; i < PP_NUM; i++) begin : g_pp
    booth_digit_t  d;
    logic [PW-1:0] mag;
    logic          neg;

    assign d   = booth_encode(b_win[2*i +: 3]);
    assign neg = (d == BD_M1) || (d == BD_M2);

    always_comb begin
      mag = '0;
      case (d)
        BD_P1, BD_M1: mag = a_w;
        BD_P2, BD_M2: mag = a_w << 1;
        default:      mag = '0;
      endcase
    end

    // Negation is ~mag here; the matching +1 lands in the correction row.
    assign rows_o[i]  = (neg ? ~mag : mag) << (2 * i);
    assign corr[2*i]  = neg;
    if (i < PP_NUM - 1) begin : g_gap
      assign corr[2*i+1] = 1'b0;
    end
  end

  assign corr[PW-1:2*PP_NUM-1] = '0;
  assign rows_o[PP_NUM]        = corr;

endmodule

// File: rtl/booth_mult_pipe.sv
// Three-stage radix-4 Booth multiplier: S1 partial products, S2 Wallace CSA
// reduction, S3 carry-lookahead add; valid/ready stream with global stall.
module booth_mult_pipe
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int PP_NUM = pp_num(WIDTH);
  localparam int NROWS  = PP_NUM + 1;
  localparam int PW     = 2 * WIDTH;
  localparam int NLVL   = csa_levels(NROWS);

  logic             advance;
  logic [WIDTH+1:0] a_ext;
  logic [WIDTH+1:0] b_ext;
  logic [PW-1:0]    pp_rows [NROWS];
  logic [PW-1:0]    csa [0:NLVL][0:NROWS-1];
  logic [PW-1:0]    cla_sum;
  logic [PW-1:0]    cla_c;

  logic             s1_v_q, s2_v_q, s3_v_q;
  logic [PW-1:0]    s1_rows_q [NROWS];
  logic [PW-1:0]    s2_sum_q, s2_carry_q, s3_prod_q;

  assign advance  = ~s3_v_q | out_ready;
  assign in_ready = advance;

  assign a_ext = {{2{signed_mode & a[WIDTH-1]}}, a};
  assign b_ext = {{2{signed_mode & b[WIDTH-1]}}, b};

  booth_pp_gen #(.WIDTH(WIDTH)) u_pp_gen (
    .a_ext_i (a_ext),
    .b_ext_i (b_ext),
    .rows_o  (pp_rows)
  );

  for (genvar r = 0; r < NROWS; r++) begin : g_l0
    assign csa[0][r] = s1_rows_q[r];
  end

  // Each level compresses rows in groups of three; leftovers pass straight down.
  for (genvar l = 0; l < NLVL; l++) begin : g_lvl
    localparam int N  = csa_rows_at(NROWS, l);
    localparam int G  = N / 3;
    localparam int NN = csa_rows_next(N);

    for (genvar g = 0; g < G; g++) begin : g_csa
      logic [PW-1:0] x, y, z;
      assign x = csa[l][3*g];
      assign y = csa[l][3*g+1];
      assign z = csa[l][3*g+2];
      assign csa[l+1][2*g]   = x ^ y ^ z;
      assign csa[l+1][2*g+1] = ((x & y) | (x & z) | (y & z)) << 1;
    end
    for (genvar r = 0; r < N - 3*G; r++) begin : g_pass
      assign csa[l+1][2*G+r] = csa[l][3*G+r];
    end
    for (genvar r = NN; r < NROWS; r++) begin : g_pad
      assign csa[l+1][r] = '0;
    end
  end

  // 4-bit lookahead groups, group carries rippled; final carry-out dropped.
  assign cla_c[0] = 1'b0;
  for (genvar k = 0; k < PW / 4; k++) begin : g_cla
    logic [3:0] g, p;
    logic       c0;
    assign g  = s2_sum_q[4*k +: 4] & s2_carry_q[4*k +: 4];
    assign p  = s2_sum_q[4*k +: 4] ^ s2_carry_q[4*k +: 4];
    assign c0 = cla_c[4*k];
    assign cla_c[4*k+1] = g[0] | (p[0] & c0);
    assign cla_c[4*k+2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign cla_c[4*k+3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                        | (p[2] & p[1] & p[0] & c0);
    if (k < PW / 4 - 1) begin : g_cout
      assign cla_c[4*k+4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                          | (p[3] & p[2] & p[1] & g[0]) | (&p & c0);
    end
    assign cla_sum[4*k +: 4] = p ^ cla_c[4*k +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      s3_v_q     <= 1'b0;
      s2_sum_q   <= '0;
      s2_carry_q <= '0;
      s3_prod_q  <= '0;
      for (int r = 0; r < NROWS; r++) s1_rows_q[r] <= '0;
    end else if (advance) begin
      s1_v_q <= in_valid;
      s2_v_q <= s1_v_q;
      s3_v_q <= s2_v_q;
      if (in_valid) s1_rows_q <= pp_rows;
      if (s1_v_q) begin
        s2_sum_q   <= csa[NLVL][0];
        s2_carry_q <= csa[NLVL][1];
      end
      if (s2_v_q) s3_prod_q <= cla_sum;
    end
  end

  assign out_valid = s3_v_q;
  assign product   = s3_prod_q;

endmodule

// File: tb/tb_booth_mult_pipe.sv
// Scoreboard bench running WIDTH=8, 16 and 32 instances side by side with
// directed corners, latency, backpressure, mid-flight reset and random traffic.
module tb_booth_mult_pipe;

  logic clk;
  int   total = 0;
  int   bad   = 0;
  bit   done_v [3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input logic [63:0] got, input logic [63:0] exp,
                     input int w, input string nm);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL w%0d %s got=%h exp=%h", w, nm, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int W = (gi == 0) ? 8 : (gi == 1) ? 16 : 32;

    logic           rst, in_valid, in_ready, signed_mode, out_valid, out_ready;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] product;
    logic [63:0]    sb_q [$];
    int             rdy_mode;

    booth_mult_pipe #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .signed_mode (signed_mode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .product     (product)
    );

    // Reference: plain integer multiply of the interpreted operands.
    function automatic logic [63:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic sm);
      longint      xv, yv, pv;
      logic [63:0] r;
      xv = sm ? longint'($signed(x)) : longint'(x);
      yv = sm ? longint'($signed(y)) : longint'(y);
      pv = xv * yv;
      r  = '0;
      r[2*W-1:0] = pv[2*W-1:0];
      return r;
    endfunction

    task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic smi);
      int t;
      bit acc;
      a = ai; b = bi; signed_mode = smi; in_valid = 1'b1;
      acc = 1'b0; t = 0;
      while (!acc && t < 200) begin
        @(negedge clk);
        acc = in_ready;
        if (acc) sb_q.push_back(model(ai, bi, smi));
        @(posedge clk); #1;
        t++;
      end
      in_valid = 1'b0;
      if (!acc) chk(64'(acc), 64'd1, W, "issue_timeout");
    endtask

    task automatic expect_valid(input logic e, input string nm);
      @(negedge clk);
      chk(64'(out_valid), 64'(e), W, nm);
    endtask

    task automatic latency_check(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                 input logic [63:0] expv, input string nm);
      issue(ai, bi, 1'b0);
      expect_valid(1'b0, {nm, "_c1"});
      expect_valid(1'b0, {nm, "_c2"});
      expect_valid(1'b1, {nm, "_c3"});
      chk(64'(product), expv, W, {nm, "_value"});
      expect_valid(1'b0, {nm, "_c4"});
      @(posedge clk); #1;
    endtask

    task automatic drain(input string nm);
      int t;
      t = 0;
      while (sb_q.size() != 0 && t < 400) begin
        @(posedge clk);
        t++;
      end
      chk(64'(sb_q.size()), 64'd0, W, {"drain_", nm});
      @(posedge clk); #1;
    endtask

    initial begin : rdy_drv
      out_ready = 1'b1;
      forever begin
        @(posedge clk); #1;
        case (rdy_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = 1'($urandom_range(0, 1));
          default: out_ready = 1'b0;
        endcase
      end
    end

    initial begin : mon
      logic           stall_prev;
      logic [2*W-1:0] held;
      stall_prev = 1'b0;
      held = '0;
      forever begin
        @(negedge clk);
        if (rst) begin
          stall_prev = 1'b0;
        end else begin
          chk(64'(in_ready), 64'(!out_valid || out_ready), W, "in_ready_rule");
          if (stall_prev) begin
            chk(64'(out_valid), 64'd1, W, "hold_valid");
            chk(64'(product), 64'(held), W, "hold_product");
          end
          if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL w%0d unexpected_output got product=%h exp no output", W, product);
            end else begin
              chk(64'(product), sb_q.pop_front(), W, "product");
            end
          end
          stall_prev = out_valid && !out_ready;
          held = product;
        end
      end
    end

    initial begin : drv
      logic [W-1:0] mn, mx, on, ra, rb;
      mn = '0; mn[W-1] = 1'b1; mx = ~mn; on = '1;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; rdy_mode = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk(64'(out_valid), 64'd0, W, "reset_out_valid");
      chk(64'(product), 64'd0, W, "reset_product");
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk(64'(in_ready), 64'd1, W, "ready_after_reset");
      @(posedge clk); #1;

      latency_check(W'(3), W'(5), 64'd15, "latency");

      // corners and mixed signs, back to back
      issue(mn, mn, 1'b1);
      issue(on, on, 1'b0);
      issue(on, on, 1'b1);
      issue('0, mx, 1'b1);
      issue('0, '0, 1'b0);
      issue(W'(-3), W'(7), 1'b1);
      issue(mn, on, 1'b1);
      issue(mx, mn, 1'b1);
      issue(mn, on, 1'b0);
      issue(W'(-3), W'(7), 1'b0);
      drain("corners");

      // backpressure: consumer stalls once the first result appears
      rdy_mode = 2;
      @(posedge clk); #1;
      fork
        begin
          issue(W'(11), W'(13), 1'b0);
          issue(W'(-5), W'(9), 1'b1);
          issue(mx, W'(2), 1'b1);
          issue(on, W'(3), 1'b0);
        end
        begin
          int t;
          t = 0;
          @(negedge clk);
          while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
          end
          chk(64'(out_valid), 64'd1, W, "bp_fill");
          chk(64'(in_ready), 64'd0, W, "bp_in_ready");
          repeat (5) @(negedge clk);
          rdy_mode = 0;
        end
      join
      drain("bp");

      // reset with two operations in flight
      issue(W'(6), W'(7), 1'b1);
      issue(W'(9), W'(2), 1'b0);
      rst = 1'b1;
      sb_q.delete();
      @(posedge clk); #1 rst = 1'b0;
      expect_valid(1'b0, "rst_c1");
      expect_valid(1'b0, "rst_c2");
      expect_valid(1'b0, "rst_c3");
      @(posedge clk); #1;
      latency_check(W'(5), W'(5), 64'd25, "post_rst");

      rdy_mode = 1;
      for (int i = 0; i < 1000; i++) begin
        ra = W'($urandom);
        rb = W'($urandom);
        if ($urandom_range(0, 7) == 0) ra = mn;
        if ($urandom_range(0, 7) == 0) rb = on;
        issue(ra, rb, 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
      end
      rdy_mode = 0;
      drain("rand");
      done_v[gi] = 1'b1;
    end
  end

  initial begin : finisher
    int t;
    t = 0;
    while (!(done_v[0] && done_v[1] && done_v[2]) && t < 30000) begin
      @(posedge clk);
      t++;
    end
    if (!(done_v[0] && done_v[1] && done_v[2])) begin
      total++;
      bad++;
      $display("FAIL sim_timeout got done=%b%b%b exp=111", done_v[0], done_v[1], done_v[2]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
